// File: rtl/pipe_control.sv
// pipe_control: ID-stage decode with a load-use stall, jump flush and ID/EX, EX/MEM, MEM/WB control registers.
module pipe_control #(
  parameter int REG_W     = 5,
  parameter int ALU_SEL_W = 4,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [5:0]           opcode,
  input  logic [REG_W-1:0]     rs,
  input  logic [REG_W-1:0]     rt,
  input  logic [REG_W-1:0]     rd,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 pc_sel,
  output logic                 if_id_flush,
  output logic                 ex_valid,
  output logic [ALU_SEL_W-1:0] ex_alu_sel,
  output logic [1:0]           ex_srcb,
  output logic                 mem_valid,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic                 wb_from_mem,
  output logic [REG_W-1:0]     wb_dst,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     stall_cnt
);
  typedef struct packed {
    logic                 v;
    logic [ALU_SEL_W-1:0] alu;
    logic [1:0]           sb;
    logic                 mr;
    logic                 mw;
    logic                 we;
    logic                 fm;
    logic [REG_W-1:0]     dst;
  } ex_t;
  typedef struct packed {
    logic             v;
    logic             mr;
    logic             mw;
    logic             we;
    logic             fm;
    logic [REG_W-1:0] dst;
  } mem_t;
  typedef struct packed {
    logic             v;
    logic             we;
    logic             fm;
    logic [REG_W-1:0] dst;
  } wb_t;
  localparam ex_t EX_BUBBLE = '{v: 1'b0, alu: ALU_SEL_W'(5), sb: 2'd0, mr: 1'b0, mw: 1'b0,
                                we: 1'b0, fm: 1'b0, dst: '0};
  logic       ok, mr, mw, we, fm, drt, jmp, hazard, issue, illegal_op_d, illegal_op_q;
  logic [3:0] alu;
  logic [1:0] sb;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  ex_t  ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;
  always_comb begin
    ok  = 1'b1;
    alu = 4'h5;
    sb  = 2'd0;
    mr  = 1'b0;
    mw  = 1'b0;
    we  = 1'b0;
    fm  = 1'b0;
    drt = 1'b0;
    jmp = 1'b0;
    case (opcode)
      6'h20, 6'h21: begin alu = 4'h0; we = 1'b1; end
      6'h22, 6'h29: begin alu = 4'h1; we = 1'b1; end
      6'h24:        begin alu = 4'h8; we = 1'b1; end
      6'h25:        begin alu = 4'h9; we = 1'b1; end
      6'h27:        begin alu = 4'hD; we = 1'b1; end
      6'h08:        begin alu = 4'h0; sb = 2'd1; we = 1'b1; drt = 1'b1; end
      6'h0C:        begin alu = 4'h8; sb = 2'd1; we = 1'b1; drt = 1'b1; end
      6'h0D:        begin alu = 4'h9; sb = 2'd1; we = 1'b1; drt = 1'b1; end
      6'h00:        begin alu = 4'h2; sb = 2'd2; we = 1'b1; end
      6'h03:        begin alu = 4'h3; sb = 2'd2; we = 1'b1; end
      6'h23:        begin alu = 4'h0; sb = 2'd1; mr = 1'b1; we = 1'b1; fm = 1'b1; drt = 1'b1; end
      6'h2B:        begin alu = 4'h0; sb = 2'd1; mw = 1'b1; end
      6'h02:        jmp = 1'b1;
      6'h0E:        ;
      default:      ok = 1'b0;
    endcase
  end
  // Only lw sets mem_rd, so ex_q.mr identifies a load sitting in EX; j reads no registers.
  assign hazard = (HAZARD_EN != 0) && ex_q.v && ex_q.mr && (ex_q.dst != '0) &&
                  ((ex_q.dst == rs) || (ex_q.dst == rt)) && id_valid && !jmp;
  assign issue  = id_valid && ok && !jmp && !hazard;
  assign ex_d   = issue ? '{v: 1'b1, alu: ALU_SEL_W'(alu), sb: sb, mr: mr, mw: mw, we: we,
                            fm: fm, dst: drt ? rt : rd} : EX_BUBBLE;
  assign mem_d  = {ex_q.v, ex_q.mr, ex_q.mw, ex_q.we, ex_q.fm, ex_q.dst};
  assign wb_d   = {mem_q.v, mem_q.we, mem_q.fm, mem_q.dst};
  assign stall_cnt_d  = (hazard && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign illegal_op_d = illegal_op_q || (id_valid && !ok);
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= EX_BUBBLE;
      mem_q        <= '0;
      wb_q         <= '0;
      stall_cnt_q  <= '0;
      illegal_op_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      stall_cnt_q  <= stall_cnt_d;
      illegal_op_q <= illegal_op_d;
    end
  end
  assign pc_en       = !hazard;
  assign if_id_en    = !hazard;
  assign pc_sel      = id_valid && jmp;
  assign if_id_flush = id_valid && jmp;
  assign ex_valid    = ex_q.v;
  assign ex_alu_sel  = ex_q.alu;
  assign ex_srcb     = ex_q.sb;
  assign mem_valid   = mem_q.v;
  assign mem_rd      = mem_q.mr;
  assign mem_wr      = mem_q.mw;
  assign wb_valid    = wb_q.v;
  assign wb_we       = wb_q.we;
  assign wb_from_mem = wb_q.fm;
  assign wb_dst      = wb_q.dst;
  assign illegal_op  = illegal_op_q;
  assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: three parameterisations driven in lockstep, checked by a scoreboard against an instruction-level pipeline model.
module tb_pipe_control;
  logic       clk = 1'b0, rst = 1'b1, id_valid = 1'b0;
  logic [5:0] opcode = 6'h0E;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [2:0][38:0] act;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 1) ? 2 : 16;
    logic pe, ie, ps, fl, exv, mv, mr, mw, wv, we, fm, il;
    logic [3:0] alu;
    logic [1:0] sb;
    logic [4:0] dst;
    logic [CW-1:0] sc;
    pipe_control #(.REG_W(5), .ALU_SEL_W(4), .CNT_W(CW), .HAZARD_EN(g == 2 ? 0 : 1)) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .pc_en(pe), .if_id_en(ie), .pc_sel(ps), .if_id_flush(fl), .ex_valid(exv),
      .ex_alu_sel(alu), .ex_srcb(sb), .mem_valid(mv), .mem_rd(mr), .mem_wr(mw),
      .wb_valid(wv), .wb_we(we), .wb_from_mem(fm), .wb_dst(dst), .illegal_op(il),
      .stall_cnt(sc));
    assign act[g] = {pe, ie, ps, fl, exv, alu, sb, mv, mr, mw, wv, we, fm, dst, il, 16'(sc)};
  end
  // Instruction semantics table: legal, alu, srcb, then mem_rd mem_wr we from_mem dst_is_rt jump.
  typedef struct packed {
    logic ok; logic [3:0] alu; logic [1:0] sb; logic mr, mw, we, fm, drt, j;
  } inf_t;
  function automatic inf_t dec(input logic [5:0] op);
    case (op)
      6'h20, 6'h21: return {1'b1, 4'h0, 2'd0, 6'b001000};
      6'h22, 6'h29: return {1'b1, 4'h1, 2'd0, 6'b001000};
      6'h24:        return {1'b1, 4'h8, 2'd0, 6'b001000};
      6'h25:        return {1'b1, 4'h9, 2'd0, 6'b001000};
      6'h27:        return {1'b1, 4'hD, 2'd0, 6'b001000};
      6'h08:        return {1'b1, 4'h0, 2'd1, 6'b001010};
      6'h0C:        return {1'b1, 4'h8, 2'd1, 6'b001010};
      6'h0D:        return {1'b1, 4'h9, 2'd1, 6'b001010};
      6'h00:        return {1'b1, 4'h2, 2'd2, 6'b001000};
      6'h03:        return {1'b1, 4'h3, 2'd2, 6'b001000};
      6'h23:        return {1'b1, 4'h0, 2'd1, 6'b101110};
      6'h2B:        return {1'b1, 4'h0, 2'd1, 6'b010000};
      6'h02:        return {1'b1, 4'h5, 2'd0, 6'b000001};
      6'h0E:        return {1'b1, 4'h5, 2'd0, 6'b000000};
      default:      return {1'b0, 4'h5, 2'd0, 6'b000000};
    endcase
  endfunction
  // Model: per instance, slots 0/1/2 = EX/MEM/WB each hold {valid, opcode, destination}.
  localparam int CMAX[3] = '{65535, 3, 65535};
  localparam bit HEN[3]  = '{1'b1, 1'b1, 1'b0};
  logic       mv[3][3];
  logic [5:0] mop[3][3];
  logic [4:0] mdst[3][3];
  int         mcnt[3];
  logic       mill[3];
  bit         known = 1'b0;
  typedef struct packed { logic [2:0][38:0] e, m; } exp_t;
  exp_t sbq[$];
  exp_t got;
  function automatic logic hz(input int k);
    inf_t d = dec(opcode);
    return HEN[k] && mv[k][0] && mop[k][0] == 6'h23 && mdst[k][0] != 0 &&
           (mdst[k][0] == rs || mdst[k][0] == rt) && id_valid && !d.j;
  endfunction
  task automatic advance();
    inf_t d = dec(opcode);
    for (int k = 0; k < 3; k++) begin
      logic h = hz(k);
      if (rst) begin
        for (int s = 0; s < 3; s++) mv[k][s] = 1'b0;
        mcnt[k] = 0;
        mill[k] = 1'b0;
      end else begin
        for (int s = 2; s > 0; s--) begin
          mv[k][s]   = mv[k][s-1];
          mop[k][s]  = mop[k][s-1];
          mdst[k][s] = mdst[k][s-1];
        end
        mv[k][0]   = id_valid && d.ok && !d.j && !h;
        mop[k][0]  = opcode;
        mdst[k][0] = d.drt ? rt : rd;
        if (h && mcnt[k] < CMAX[k]) mcnt[k]++;
        if (id_valid && !d.ok) mill[k] = 1'b1;
      end
    end
    if (rst) known = 1'b1;
  endtask
  function automatic exp_t build();
    exp_t x;
    inf_t d = dec(opcode);
    for (int k = 0; k < 3; k++) begin
      logic h = hz(k);
      logic jp = id_valid && d.j && !h;
      inf_t e = dec(mop[k][0]);
      inf_t m = dec(mop[k][1]);
      inf_t w = dec(mop[k][2]);
      x.e[k] = {!h, !h, jp, jp, mv[k][0], mv[k][0] ? e.alu : 4'h5, e.sb,
                mv[k][1], mv[k][1] & m.mr, mv[k][1] & m.mw,
                mv[k][2], mv[k][2] & w.we, w.fm, mdst[k][2], mill[k], 16'(mcnt[k])};
      x.m[k] = {9'h1FF, {2{mv[k][0]}}, 5'h1F, mv[k][2], {5{mv[k][2]}}, 17'h1FFFF};
    end
    return x;
  endfunction
  task automatic step(input logic r, input logic v, input logic [5:0] op,
                      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    @(posedge clk);
    #1;
    advance();
    rst = r; id_valid = v; opcode = op; rs = s; rt = t; rd = d;
    if (known) sbq.push_back(build());
  endtask
  // Emulates the fetch side: a stalled instruction is re-presented, a jump's slot is flushed.
  task automatic issue(input logic v, input logic [5:0] op,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    inf_t i = dec(op);
    step(1'b0, v, op, s, t, d);
    if (hz(0)) step(1'b0, v, op, s, t, d);
    else if (v && i.j) step(1'b0, 1'b0, 6'h0E, 5'd0, 5'd0, 5'd0);
  endtask
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      got = sbq.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (((act[k] ^ got.e[k]) & got.m[k]) != 0) begin
          n_fail++;
          $display("FAIL outputs inst%0d t=%0t got=%h want=%h care=%h",
                   k, $time, act[k], got.e[k], got.m[k]);
        end
      end
    end
  end
  logic [5:0] ops[20] = '{6'h20, 6'h21, 6'h22, 6'h29, 6'h24, 6'h25, 6'h27, 6'h08, 6'h0C, 6'h0D,
                          6'h00, 6'h03, 6'h23, 6'h23, 6'h23, 6'h2B, 6'h02, 6'h0E, 6'h3F, 6'h11};
  initial begin
    step(1'b1, 1'b0, 6'h0E, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 6'h20, 5'd1, 5'd2, 5'd3);
    issue(1'b1, 6'h20, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) issue(1'b0, 6'h0E, 5'd0, 5'd0, 5'd0);
    issue(1'b1, 6'h23, 5'd0, 5'd5, 5'd0);
    issue(1'b1, 6'h20, 5'd5, 5'd1, 5'd7);
    issue(1'b1, 6'h23, 5'd0, 5'd0, 5'd0);
    issue(1'b1, 6'h20, 5'd0, 5'd1, 5'd7);
    issue(1'b1, 6'h02, 5'd5, 5'd5, 5'd0);
    issue(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3);
    issue(1'b1, 6'h21, 5'd1, 5'd2, 5'd4);
    step(1'b1, 1'b0, 6'h0E, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 6'h23, 5'd0, 5'd5, 5'd0);
      issue(1'b1, 6'h20, 5'd5, 5'd1, 5'd7);
    end
    step(1'b0, 1'b1, 6'h23, 5'd0, 5'd5, 5'd0);
    step(1'b1, 1'b1, 6'h20, 5'd5, 5'd1, 5'd2);
    step(1'b0, 1'b0, 6'h0E, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 19)], 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      else
        issue(1'($urandom_range(0, 4) != 0), ops[$urandom_range(0, 19)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end
    repeat (3) step(1'b0, 1'b0, 6'h0E, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
